// File: rtl/rotating_counter_display_if.sv
// Bundles the control inputs and display outputs of rotating_counter_display.
// The master side drives en/up; the slave side (the display block) drives cnt/rot/seg.
interface rotating_counter_display_if #(
  parameter int CH = 2,
  parameter int W  = 3
);
  localparam int RW = (CH > 1) ? $clog2(CH) : 1;

  logic            en;
  logic [CH-1:0]   up;
  logic [CH*W-1:0] cnt;
  logic [RW-1:0]   rot;
  logic [CH*7-1:0] seg;

  modport master (output en, output up, input cnt, input rot, input seg);
  modport slave  (input en, input up, output cnt, output rot, output seg);
endinterface

// File: rtl/rotating_counter_display.sv
// Multi-channel modulo counter with per-channel rate division and direction,
// periodically rotating which channel each 7-segment digit shows.
module rotating_counter_display #(
  parameter int CH        = 2,
  parameter int MOD       = 6,
  parameter int W         = 3,
  parameter int DIV_BASE  = 23,
  parameter int ROT_TICKS = 30
) (
  input logic                     clk,
  input logic                     rst,
  rotating_counter_display_if.slave bus
);
  localparam int PW  = DIV_BASE + CH - 1;
  localparam int RW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int RCW = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;

  localparam logic [W-1:0]   CNT_MAX = W'(MOD - 1);
  localparam logic [RW-1:0]  ROT_MAX = RW'(CH - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(ROT_TICKS - 1);

  logic [PW-1:0]  pre;
  logic [W-1:0]   cnt_r [CH];
  logic [RCW-1:0] rc;
  logic [RW-1:0]  rot_r;
  logic [CH-1:0]  tick;

  function automatic logic [W-1:0] cnt_up(input logic [W-1:0] v);
    return (v == CNT_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [W-1:0] cnt_down(input logic [W-1:0] v);
    return (v == '0) ? CNT_MAX : v - 1'b1;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; out-of-range values blank the digit.
  function automatic logic [6:0] seg_decode(input logic [W-1:0] v);
    logic [6:0] s;
    if (32'(v) >= MOD) begin
      s = 7'h7F;
    end else begin
      case (32'(v))
        0:       s = 7'h40;
        1:       s = 7'h79;
        2:       s = 7'h24;
        3:       s = 7'h30;
        4:       s = 7'h19;
        5:       s = 7'h12;
        6:       s = 7'h02;
        7:       s = 7'h78;
        8:       s = 7'h00;
        9:       s = 7'h10;
        default: s = 7'h7F;
      endcase
    end
    return s;
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign tick[i] = bus.en & (&pre[DIV_BASE+i-1:0]);
    assign bus.cnt[i*W +: W] = cnt_r[i];
  end

  assign bus.rot = rot_r;

  // The rotation step uses the pre-edge rc, so it lands on the same edge as the counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      rc    <= '0;
      rot_r <= '0;
      for (int i = 0; i < CH; i++) cnt_r[i] <= '0;
    end else begin
      if (bus.en) pre <= pre + 1'b1;
      for (int i = 0; i < CH; i++) begin
        if (tick[i]) cnt_r[i] <= bus.up[i] ? cnt_up(cnt_r[i]) : cnt_down(cnt_r[i]);
      end
      if (tick[CH-1]) begin
        if (rc == RC_LAST) begin
          rc    <= '0;
          rot_r <= (rot_r == ROT_MAX) ? '0 : rot_r + 1'b1;
        end else begin
          rc <= rc + 1'b1;
        end
      end
    end
  end

  for (genvar d = 0; d < CH; d++) begin : g_digit
    logic [W-1:0] shown;

    always_comb begin
      shown = '0;
      for (int c = 0; c < CH; c++) begin
        if (((d + int'(rot_r)) % CH) == c) shown = cnt_r[c];
      end
    end

    assign bus.seg[d*7 +: 7] = seg_decode(shown);
  end
endmodule

// File: tb/tb_rotating_counter_display.sv
// Self-checking bench: hand-derived vector table plus a model-driven random run,
// both feeding expected results through a scoreboard queue.
module tb_rotating_counter_display;
  localparam int CH        = 2;
  localparam int MOD       = 6;
  localparam int W         = 3;
  localparam int DIV_BASE  = 2;
  localparam int ROT_TICKS = 3;

  logic clk = 1'b0;
  logic rst;

  rotating_counter_display_if #(.CH(CH), .W(W)) bus ();

  rotating_counter_display #(
    .CH(CH), .MOD(MOD), .W(W), .DIV_BASE(DIV_BASE), .ROT_TICKS(ROT_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] up;
    int         edges;
    logic [5:0] cnt;
    logic       rot;
    logic [13:0] seg;
  } vec_t;

  typedef struct {
    logic [5:0]  cnt;
    logic        rot;
    logic [13:0] seg;
    int          tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  int m_act;
  int m_cnt [CH];
  int m_t1;

  function automatic vec_t mkVec(input logic r, input logic e, input logic [1:0] u, input int n,
                                 input logic [2:0] c1, input logic [2:0] c0, input logic ro,
                                 input logic [13:0] s);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.edges = n;
    v.cnt = {c1, c0}; v.rot = ro; v.seg = s;
    return v;
  endfunction

  function automatic logic [6:0] segOf(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: counts are tracked as plain integers against the active-edge count.
  task automatic modelStep(input logic r, input logic e, input logic [1:0] u);
    if (r) begin
      m_act = 0; m_t1 = 0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else if (e) begin
      for (int i = 0; i < CH; i++) begin
        if (((m_act + 1) % (1 << (DIV_BASE + i))) == 0) begin
          m_cnt[i] = u[i] ? (m_cnt[i] + 1) % MOD : (m_cnt[i] + MOD - 1) % MOD;
          if (i == CH - 1) m_t1++;
        end
      end
      m_act++;
    end
  endtask

  function automatic exp_t modelExp(input int tag);
    exp_t x;
    int ro;
    ro = (m_t1 / ROT_TICKS) % CH;
    x.cnt = {3'(m_cnt[1]), 3'(m_cnt[0])};
    x.rot = 1'(ro);
    x.seg = '0;
    for (int d = 0; d < CH; d++) x.seg[d*7 +: 7] = segOf(m_cnt[(d + ro) % CH]);
    x.tag = tag;
    return x;
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s tag=%0d got=%h expected=%h", nm, tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] u, input exp_t x);
    rst    = r;
    bus.en = e;
    bus.up = u;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty got=0 expected=1");
    end else begin
      x = sb.pop_front();
      cmp("cnt", x.tag, 32'(bus.cnt), 32'(x.cnt));
      cmp("rot", x.tag, 32'(bus.rot), 32'(x.rot));
      cmp("seg", x.tag, 32'(bus.seg), 32'(x.seg));
    end
  endtask

  task automatic runEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t x;
    logic r, e;
    logic [1:0] u;

    rst    = 1'b1;
    bus.en = 1'b1;
    bus.up = 2'b11;

    // Main schedule, rotation and wrap
    vecs.push_back(mkVec(1, 1, 2'b11,  1, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  3, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 0, 1, 0, 14'h2079));
    vecs.push_back(mkVec(0, 1, 2'b11,  4, 1, 2, 0, 14'h3CA4));
    vecs.push_back(mkVec(0, 1, 2'b11,  8, 2, 4, 0, 14'h1219));
    vecs.push_back(mkVec(0, 1, 2'b11,  7, 2, 5, 0, 14'h1212));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 3, 0, 1, 14'h2030));
    vecs.push_back(mkVec(0, 1, 2'b11, 23, 5, 5, 1, 14'h0912));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 0, 0, 0, 14'h2040));
    // Down-counting channel 0
    vecs.push_back(mkVec(1, 1, 2'b10,  1, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b10,  4, 0, 5, 0, 14'h2012));
    vecs.push_back(mkVec(0, 1, 2'b10,  4, 1, 4, 0, 14'h3C99));
    // Enable freeze over edges 5..20
    vecs.push_back(mkVec(1, 1, 2'b11,  1, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  4, 0, 1, 0, 14'h2079));
    vecs.push_back(mkVec(0, 0, 2'b11, 16, 0, 1, 0, 14'h2079));
    vecs.push_back(mkVec(0, 1, 2'b11,  3, 0, 1, 0, 14'h2079));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 1, 2, 0, 14'h3CA4));
    // Reset at edge 10 discards prescaler and rc progress
    vecs.push_back(mkVec(1, 1, 2'b11,  1, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  9, 1, 2, 0, 14'h3CA4));
    vecs.push_back(mkVec(1, 1, 2'b11,  1, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  3, 0, 0, 0, 14'h2040));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 0, 1, 0, 14'h2079));
    vecs.push_back(mkVec(0, 1, 2'b11, 19, 2, 5, 0, 14'h1212));
    vecs.push_back(mkVec(0, 1, 2'b11,  1, 3, 0, 1, 14'h2030));

    // Reset held for several edges must keep every output at its reset value
    for (int k = 0; k < 5; k++) begin
      x.cnt = '0; x.rot = 1'b0; x.seg = 14'h2040; x.tag = 100 + k;
      applyStimulus(1'b1, 1'b1, 2'b11, x);
      runEdges(1);
      checkOutput();
    end

    for (int v = 0; v < vecs.size(); v++) begin
      x.cnt = vecs[v].cnt; x.rot = vecs[v].rot; x.seg = vecs[v].seg; x.tag = v;
      applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].up, x);
      runEdges(vecs[v].edges);
      checkOutput();
    end

    // Random en/up/rst traffic against the integer model, checked every edge
    modelStep(1'b1, 1'b1, 2'b11);
    applyStimulus(1'b1, 1'b1, 2'b11, modelExp(1000));
    runEdges(1);
    checkOutput();
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 60) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 2'($urandom);
      modelStep(r, e, u);
      applyStimulus(r, e, u, modelExp(2000 + n));
      runEdges(1);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
